// File: rtl/result_serializer.sv
// result_serializer
//
// Converts an unsigned binary result into NDIG BCD digits with a
// double-dabble engine (one iteration per clock), then streams the digits
// one per clock as (pos, dig) write commands to the seven-segment display
// controller, units digit first. Values above 99_999_999 saturate to all
// nines and raise ovf.
//
// Handshake: start is a single-cycle request, accepted on a rising edge
// only while busy is low; the accepting edge latches value. Requests
// seen while busy is high are dropped, not queued. There is no
// backpressure: the display side must accept one (pos, dig) pair per clock.
//
// Ports:
//   clock      in   system clock, rising edge active
//   reset      in   asynchronous, active-high reset
//   start      in   request to convert and emit value
//   value      in   [WIDTH-1:0] unsigned binary result
//   dig        out  [3:0] BCD digit (0 when idle)
//   pos        out  [3:0] display position, 1 = units .. 8 = ten-millions,
//                   4'hF when idle (a no-op for the display controller)
//   busy       out  high from the accepting edge until emission ends
//   done       out  one-cycle pulse after the last digit was issued
//   ovf        out  last accepted value exceeded 99_999_999
//   fsm_state  out  [1:0] current FSM state, for debug/checkers
//                   (0 = IDLE, 1 = CONVERT, 2 = EMIT)
//
// Timing (E0 = accepting edge): E1..E27 conversion, E28..E35 digits 1..8,
// E36 done pulse with busy low. A start during the done cycle is accepted.

module result_serializer #(
    parameter int NDIG  = 8,
    parameter int WIDTH = 27
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic [3:0]       dig,
    output logic [3:0]       pos,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        EMIT    = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(99_999_999);
    localparam logic [4:0]       LAST_ITER = 5'(WIDTH - 1);
    localparam logic [3:0]       IDX_END   = 4'(NDIG + 1);
    localparam logic [3:0]       POS_IDLE  = 4'hF;

    state_t                state, state_n;
    logic [WIDTH-1:0]      bin_q, bin_n;
    logic [4*NDIG-1:0]     bcd_q, bcd_n;
    logic [4*NDIG-1:0]     adj;
    logic [4:0]            iter_q, iter_n;
    logic [3:0]            idx_q, idx_n;
    logic                  big_q, big_n;
    logic [3:0]            dig_n, pos_n;
    logic                  busy_n, done_n, ovf_n;

    assign fsm_state = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            bin_q  <= '0;
            bcd_q  <= '0;
            iter_q <= '0;
            idx_q  <= '0;
            big_q  <= 1'b0;
            dig    <= 4'd0;
            pos    <= POS_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            state  <= state_n;
            bin_q  <= bin_n;
            bcd_q  <= bcd_n;
            iter_q <= iter_n;
            idx_q  <= idx_n;
            big_q  <= big_n;
            dig    <= dig_n;
            pos    <= pos_n;
            busy   <= busy_n;
            done   <= done_n;
            ovf    <= ovf_n;
        end
    end

    always_comb begin
        state_n = state;
        bin_n   = bin_q;
        bcd_n   = bcd_q;
        iter_n  = iter_q;
        idx_n   = idx_q;
        big_n   = big_q;
        dig_n   = 4'd0;
        pos_n   = POS_IDLE;
        busy_n  = busy;
        done_n  = 1'b0;
        ovf_n   = ovf;

        // Double-dabble correction: any nibble >= 5 would carry past 9
        // after the doubling shift, so pre-add 3.
        adj = bcd_q;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (start) begin
                    bin_n   = value;
                    bcd_n   = '0;
                    iter_n  = '0;
                    ovf_n   = 1'b0;
                    // Remember saturation now; the binary copy is shifted away.
                    big_n   = (value > MAX_VAL);
                    busy_n  = 1'b1;
                    state_n = CONVERT;
                end
            end

            CONVERT: begin
                {bcd_n, bin_n} = {adj, bin_q} << 1;
                iter_n = iter_q + 5'd1;
                if (iter_q == LAST_ITER) begin
                    idx_n   = 4'd1;
                    state_n = EMIT;
                    if (big_q) begin
                        ovf_n = 1'b1;
                        bcd_n = {NDIG{4'h9}};
                    end
                end
            end

            EMIT: begin
                // idx runs 1..NDIG for the digits; the extra step at
                // NDIG+1 produces the registered done pulse.
                if (idx_q == IDX_END) begin
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    pos_n = idx_q;
                    dig_n = 4'(bcd_q >> {idx_q - 4'd1, 2'b00});
                    idx_n = idx_q + 4'd1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_result_serializer.sv
// Testbench for result_serializer: a cycle-level reference model derived
// from the conversion/timing rules, a per-cycle compare process, directed
// runs with hand-computed digit strings, and a small display-register
// model that captures each (pos, dig) pair on the following edge.

module tb_result_serializer;

    localparam int WIDTH = 27;
    localparam int NDIG  = 8;

    // ---------------- clock / reset / DUT ----------------
    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] value;
    logic [3:0]       dig;
    logic [3:0]       pos;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [1:0]       fsm_state;

    always #5 clock = ~clock;

    result_serializer #(.NDIG(NDIG), .WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .value     (value),
        .dig       (dig),
        .pos       (pos),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf),
        .fsm_state (fsm_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // k-th decimal digit (k = 0 is units) of v, saturated to 9s above 99_999_999.
    function automatic logic [3:0] model_digit(input logic [WIDTH-1:0] v, input int k);
        int unsigned x;
        if (v > 27'd99_999_999) return 4'd9;
        x = 32'(v);
        for (int j = 0; j < k; j++) x = x / 10;
        return 4'(x % 10);
    endfunction

    bit               m_active = 1'b0;
    int               m_n      = 0;     // edges since the accepting edge
    logic [WIDTH-1:0] m_val    = '0;
    logic             m_ovf    = 1'b0;
    logic [3:0]       e_dig    = 4'd0;
    logic [3:0]       e_pos    = 4'hF;
    logic             e_busy   = 1'b0;
    logic             e_done   = 1'b0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_active = 1'b0;
            m_n      = 0;
            m_ovf    = 1'b0;
            e_pos    = 4'hF;
            e_dig    = 4'd0;
            e_busy   = 1'b0;
            e_done   = 1'b0;
        end else begin
            e_done = 1'b0;
            if (!m_active) begin
                if (start) begin
                    m_active = 1'b1;
                    m_n      = 0;
                    m_val    = value;
                    m_ovf    = 1'b0;
                end
            end else begin
                m_n++;
                if (m_n == 27) m_ovf = (m_val > 27'd99_999_999);
                if (m_n == 36) begin
                    m_active = 1'b0;
                    e_done   = 1'b1;
                end
            end
            e_busy = m_active;
            if (m_active && m_n >= 28 && m_n <= 35) begin
                e_pos = 4'(m_n - 27);
                e_dig = model_digit(m_val, m_n - 28);
            end else begin
                e_pos = 4'hF;
                e_dig = 4'd0;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clock) begin
        if (!reset && chk_en) begin
            check("cyc_pos",  32'(pos),  32'(e_pos));
            check("cyc_dig",  32'(dig),  32'(e_dig));
            check("cyc_busy", 32'(busy), 32'(e_busy));
            check("cyc_done", 32'(done), 32'(e_done));
            check("cyc_ovf",  32'(ovf),  32'(m_ovf));
        end
    end

    // ---------------- scoreboard / collectors ----------------
    logic [7:0] emit_q[$];   // observed {pos, dig}
    logic [7:0] exp_q[$];    // expected {pos, dig}
    int         busy_cnt = 0;
    int         done_cnt = 0;
    logic [3:0] disp [NDIG];

    always @(negedge clock) begin
        if (!reset) begin
            if (pos != 4'hF) emit_q.push_back({pos, dig});
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
    end

    // Display controller data register: captures valid pairs on the next edge.
    always @(posedge clock) begin
        if (!reset && pos >= 4'd1 && pos <= 4'd8 && dig <= 4'd9) disp[pos - 4'd1] <= dig;
    end

    // ---------------- driver ----------------
    // Called at a point just after a negedge; issues start so that the next
    // posedge is E0, then waits (bounded) for done and scores the run.
    // ghost_at != 0 pulses a second start (value 99) so it is sampled at E<ghost_at>.
    task automatic run(input logic [WIDTH-1:0] v, input logic [31:0] exp_digits,
                       input logic exp_ovf, input int ghost_at, input string tag);
        int done_at;
        emit_q.delete();
        exp_q.delete();
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < NDIG; i++) exp_q.push_back({4'(i + 1), exp_digits[4*i +: 4]});

        start = 1'b1;
        value = v;
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
        #1;
        check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
        check({tag, "_ovf_after_accept"},  32'(ovf),  32'd0);

        done_at = -1;
        for (int c = 1; c <= 45 && done_at < 0; c++) begin
            if (ghost_at != 0 && c == ghost_at) begin
                start = 1'b1;
                value = 27'd99;
                @(posedge clock);
                #1 start = 1'b0;
            end
            @(negedge clock);
            #1;
            if (done) done_at = c;
        end
        check({tag, "_done_latency"}, 32'(done_at), 32'd36);
        check({tag, "_busy_cycles"},  32'(busy_cnt), 32'd36);
        check({tag, "_ovf"},          32'(ovf), 32'(exp_ovf));

        if (ghost_at != 0) begin
            repeat (40) @(negedge clock);
            #1;
        end
        check({tag, "_done_count"},   32'(done_cnt), 32'd1);
        check({tag, "_emit_count"},   32'(emit_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < NDIG && i < emit_q.size(); i++)
            check({tag, "_emit"}, 32'(emit_q[i]), 32'(exp_q[i]));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1;
        start = 1'b0;
        value = '0;
        for (int i = 0; i < NDIG; i++) disp[i] = 4'hF;
        repeat (3) @(negedge clock);
        #1;
        check("reset_pos",   32'(pos),  32'hF);
        check("reset_dig",   32'(dig),  32'd0);
        check("reset_busy",  32'(busy), 32'd0);
        check("reset_done",  32'(done), 32'd0);
        check("reset_ovf",   32'(ovf),  32'd0);
        check("reset_state", 32'(fsm_state), 32'd0);
        @(negedge clock);
        reset  = 1'b0;
        chk_en = 1'b1;
        @(negedge clock);
        #1;

        run(27'd12_345_678,  32'h1234_5678, 1'b0, 0,  "v12345678");
        run(27'd0,           32'h0000_0000, 1'b0, 0,  "zero");
        run(27'd100_000_000, 32'h9999_9999, 1'b1, 0,  "ovf");
        // Issued in the done cycle of the previous run: back-to-back accept.
        run(27'd5,           32'h0000_0005, 1'b0, 0,  "five");
        run(27'd42,          32'h0000_0042, 1'b0, 10, "ghost");
        run(27'd87_654_321,  32'h8765_4321, 1'b0, 0,  "disp");
        for (int i = 0; i < NDIG; i++) check("disp_reg", 32'(disp[i]), 32'(i + 1));

        // Asynchronous reset in the middle of emission.
        start = 1'b1;
        value = 27'd11_111_111;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (31) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check("arst_pos",  32'(pos),  32'hF);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_dig",  32'(dig),  32'd0);
        emit_q.delete();
        busy_cnt = 0;
        done_cnt = 0;
        @(negedge clock);
        #1 reset = 1'b0;
        repeat (45) @(negedge clock);
        #1;
        check("arst_no_emit", 32'(emit_q.size()), 32'd0);
        check("arst_no_done", 32'(done_cnt), 32'd0);
        check("arst_no_busy", 32'(busy_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
